regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V datapath; successor to the single-write, dual-read 64-bit register file.
- Provides NRD combinational read ports and NWR clocked write ports.
- Includes a per-register busy scoreboard used by the hazard unit for load-use and multi-cycle stalls.
- x0 is hardwired to zero. All state clears on asynchronous reset; no file preload.

Parameters:
- XLEN, 64, data width in bits
- NREGS, 32, number of architectural registers (power of 2, >=2)
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..2)
- AW, $clog2(NREGS), register address width (derived; do not override)

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- RegWrite  in  NWR  per-port write enable
- WriteReg  in  NWR*AW  per-port write address, port k at bits [k*AW +: AW]
- WriteData  in  NWR*XLEN  per-port write data
- ReadReg  in  NRD*AW  per-port read address
- ReadData  out  NRD*XLEN  per-port read data
- ReadBusy  out  NRD  scoreboard busy bit of each read address
- Alloc  in  1  mark register AllocReg busy (producer issued)
- AllocReg  in  AW  register to mark busy
- AnyBusy  out  1  OR of all busy bits

Behaviour:
- Reset: one clock, asynchronous, active-high; clk and reset are the port names.
  - While reset=1: all registers = 0, all busy bits = 0.
  - Therefore ReadData=0, ReadBusy=0, AnyBusy=0.
  - Reset asserted mid-write: the write is lost. First write is accepted on the first rising edge with reset=0.
- Write:
  - On posedge clk, port k writes WriteData[k] to regs[WriteReg[k]] when RegWrite[k]=1 and WriteReg[k]!=0.
  - Writes to x0 are discarded.
- Write collision (NWR=2, same nonzero address, both enabled): the higher-indexed port (port 1) wins. No error flag.
- Read: combinational, zero latency. ReadData[j] = regs[ReadReg[j]].
  - ReadReg[j]=0 always returns 0, regardless of bypass.
- Same-cycle write/read of one address: behaviour depends on REGFILE_BYPASS_EN (see Optional Feature).
- Scoreboard: one busy bit per register; bit 0 is constant 0.
  - Set on posedge when Alloc=1 and AllocReg!=0.
  - Cleared on posedge when any write port writes that register.
  - Same edge, same register, Alloc and write both present: set wins (a new producer supersedes the completing one), data is still written.
  - Alloc on an already-busy register: the bit stays 1. No counting; the pipeline guarantees at most one outstanding producer per register.
  - ReadBusy[j] = busy[ReadReg[j]], combinational, unaffected by bypass.
  - AnyBusy is combinational from the busy bits.
- Out-of-range addresses cannot occur (AW derived from NREGS).
- No X-propagation: all registers are defined after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-through forwarding.
  - If any enabled write port targets ReadReg[j]!=0 in the current cycle, ReadData[j] returns that WriteData.
  - On a collision, the port-1 data is returned.
  - The bypass path is combinational from WriteData to ReadData.
- Undefined: no forwarding.
  - ReadData returns the stored (pre-edge) value; new data is visible the cycle after the write edge.
  - This relies on the external half-cycle scheme or hazard unit.
- Scoreboard behaviour is identical in both builds.

Test Plan:
- Reset then read all: assert reset 3 cycles, release. ReadReg = 0..31 on every port -> ReadData=0, ReadBusy=0, AnyBusy=0.
- Basic write/read: write x5=64'hDEAD_BEEF_0000_0001. Next cycle ReadReg0=5 -> that value. Write x0=64'hFFFF... -> reading x0 returns 0.
- Collision (NWR=2): both ports write x7, port0=64'h1, port1=64'h2. Next cycle x7 reads 64'h2.
- Same-cycle read of the written register, x9 old=64'h10, write 64'h20, ReadReg0=9:
  - With REGFILE_BYPASS_EN -> 64'h20 in the same cycle.
  - Without it -> 64'h10, then 64'h20 the next cycle.
- Scoreboard:
  - Alloc x3 -> next cycle ReadBusy(3)=1, AnyBusy=1.
  - Write x3 -> busy clears the following cycle.
  - Alloc x4 and write x4 on the same edge -> busy(4)=1 and data updated.
  - Alloc x0 -> busy(0) stays 0.
- Async reset mid-operation: x12 written and busy; assert reset between clock edges -> ReadData and ReadBusy go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port integer register file with busy scoreboard.
//
// Holds NREGS architectural registers of XLEN bits. x0 reads as zero and
// ignores writes. Reads are combinational, and writes happen on the rising
// edge of clk. Each register also has a busy bit. The hazard unit sets a busy
// bit when it issues a producer and the bit clears when that register is
// written back.
//
// Build option:
//   REGFILE_BYPASS_EN  When defined, a read of a register that is being
//                      written in the same cycle returns the incoming write
//                      data (write-through forwarding). When undefined, the
//                      read returns the stored pre-edge value.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset; clears all data and busy bits
//   RegWrite   [NWR]       per-port write enable
//   WriteReg   [NWR*AW]    per-port write address, port k at [k*AW +: AW]
//   WriteData  [NWR*XLEN]  per-port write data, port k at [k*XLEN +: XLEN]
//   ReadReg    [NRD*AW]    per-port read address
//   ReadData   [NRD*XLEN]  per-port read data (combinational)
//   ReadBusy   [NRD]       busy bit of each read address (never bypassed)
//   Alloc      mark AllocReg busy on the next edge
//   AllocReg   [AW]        register to mark busy
//   AnyBusy    OR of all busy bits
module regfile_mp #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NWR-1:0]      RegWrite,
  input  logic [NWR*AW-1:0]   WriteReg,
  input  logic [NWR*XLEN-1:0] WriteData,
  input  logic [NRD*AW-1:0]   ReadReg,
  output logic [NRD*XLEN-1:0] ReadData,
  output logic [NRD-1:0]      ReadBusy,
  input  logic                Alloc,
  input  logic [AW-1:0]       AllocReg,
  output logic                AnyBusy
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  // One-hot decode of each write port. A write to x0 never produces a hit,
  // so the storage, the scoreboard and the bypass all discard it.
  logic [NREGS-1:0] wr_hit [NWR];
  logic [NREGS-1:0] wr_any;
  logic [NREGS-1:0] alloc_hit;
  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    wr_any = '0;
    for (int k = 0; k < NWR; k++) begin
      wr_hit[k] = '0;
      if (RegWrite[k] && (WriteReg[k*AW +: AW] != '0)) begin
        wr_hit[k][WriteReg[k*AW +: AW]] = 1'b1;
      end
      wr_any = wr_any | wr_hit[k];
    end
  end

  always_comb begin
    alloc_hit = '0;
    if (Alloc && (AllocReg != '0)) begin
      alloc_hit[AllocReg] = 1'b1;
    end
  end

  // A new producer that is issued on the same edge as the completing
  // write-back takes priority, so the set term is ORed after the clear term.
  always_comb begin
    busy_nxt    = alloc_hit | (busy & ~wr_any);
    busy_nxt[0] = 1'b0;
  end

  // Storage and scoreboard state. The ports are scanned in ascending order,
  // so on a collision the higher-indexed port is written last and wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_hit[k][r]) begin
            regs[r] <= WriteData[k*XLEN +: XLEN];
          end
        end
      end
      busy <= busy_nxt;
    end
  end

  // Read ports. The forced zero for x0 comes last, so x0 reads as zero even
  // when the bypass is enabled.
  always_comb begin
    ReadData = '0;
    ReadBusy = '0;
    for (int j = 0; j < NRD; j++) begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;
      ra = ReadReg[j*AW +: AW];
      rd = regs[ra];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++) begin
        if (wr_hit[k][ra]) begin
          rd = WriteData[k*XLEN +: XLEN];
        end
      end
`endif
      if (ra == '0) begin
        rd = '0;
      end
      ReadData[j*XLEN +: XLEN] = rd;
      ReadBusy[j]              = busy[ra];
    end
  end

  assign AnyBusy = |busy;

endmodule
